jk_seq_checker: RTL

- Active driver/checker for the other end of the JK flip-flop interface: generates the J/K stimulus and samples the Q response.
- Forces the DUT flop to a known state, plays a programmable command sequence, and compares Q every cycle against an internal JK reference model.
- Reports pass/fail, an error count and the first failing step.
- Sits beside any JK flop (or JK-built register bit) as a self-checking harness usable in RTL and on silicon.

---
 rtl/jk_seq_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/jk_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_checker
// Desc     : Drives J/K into a flop under test and checks its Q each cycle
//            against an internal JK reference model.
//            Define JK_CHK_STOP_ON_ERR_EN to abort a run on the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_checker #(
    parameter int SEQ_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEQ_LEN-1:0] seq_cmd,
    input  logic                 q_in,
    output logic                 j,
    output logic                 k,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [IDX_W-1:0]     first_err_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W-1:0] c_last_step = IDX_W'(SEQ_LEN);
    localparam logic [IDX_W-1:0] c_no_err    = '1;
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
`ifdef JK_CHK_STOP_ON_ERR_EN
    localparam bit c_stop_on_err = 1'b1;
`else
    localparam bit c_stop_on_err = 1'b0;
`endif

    logic [2:0]           r_state;
    logic [2*SEQ_LEN-1:0] r_shadow;
    logic [IDX_W-1:0]     r_drv_step;   // step currently presented on j/k
    logic                 r_cmp_vld;
    logic [IDX_W-1:0]     r_cmp_step;
    logic                 r_m;
    logic                 r_j, r_k, r_busy, r_done, r_pass;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [IDX_W-1:0]     r_first_err_idx;

    logic [1:0]           w_cmd;
    logic                 w_mismatch;
    logic                 w_finish;
    logic [CNT_W-1:0]     w_err_next;

    always_comb begin
        w_cmd = 2'b00;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (r_drv_step == IDX_W'(i)) w_cmd = r_shadow[2*i +: 2];
        end
    end

    always_comb begin
        w_mismatch = r_cmp_vld && (r_state == S_RUN || r_state == S_DRAIN) && (q_in != r_m);
        w_err_next = (w_mismatch && r_err_cnt != c_cnt_max) ? r_err_cnt + 1'b1 : r_err_cnt;
        // DRAIN always holds the last compare, so the run ends on that edge
        w_finish   = (r_state == S_DRAIN) || (c_stop_on_err && w_mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_shadow        <= '0;
            r_drv_step      <= '0;
            r_cmp_vld       <= 1'b0;
            r_cmp_step      <= '0;
            r_m             <= 1'b0;
            r_j             <= 1'b0;
            r_k             <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_cnt       <= '0;
            r_first_err_idx <= c_no_err;
        end else begin
            // Reference model samples j/k on the same edge as the flop under test
            case ({r_j, r_k})
                2'b01:   r_m <= 1'b0;
                2'b10:   r_m <= 1'b1;
                2'b11:   r_m <= ~r_m;
                default: r_m <= r_m;
            endcase

            r_err_cnt <= w_err_next;
            if (w_mismatch && r_err_cnt == '0) r_first_err_idx <= r_cmp_step;

            if (w_finish) begin
                r_j       <= 1'b0;
                r_k       <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_pass    <= (w_err_next == '0);
                r_cmp_vld <= 1'b0;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_shadow        <= seq_cmd;
                            r_err_cnt       <= '0;
                            r_first_err_idx <= c_no_err;
                            r_busy          <= 1'b1;
                            r_pass          <= 1'b0;
                            r_drv_step      <= '0;
                            r_j             <= 1'b0;
                            r_k             <= 1'b1;
                            r_state         <= S_INIT;
                        end
                    end
                    S_INIT, S_RUN: begin
                        r_cmp_vld  <= 1'b1;
                        r_cmp_step <= r_drv_step;
                        if (r_drv_step == c_last_step) begin
                            r_j     <= 1'b0;
                            r_k     <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            {r_j, r_k} <= w_cmd;
                            r_drv_step <= r_drv_step + 1'b1;
                            r_state    <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign j             = r_j;
    assign k             = r_k;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire
